// File: rtl/video_axil_pkg.sv
// Shared types and constants for the video control AXI4-Lite master.
package video_axil_pkg;

  // Transaction sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RSP
  } state_e;

  // AXI response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_watchdog.sv
// Saturating cycle counter that flags a transaction outstanding for too long.
module axil_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic flag_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear wins over enable; stop at the limit instead of wrapping.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign flag_o = (count_q == LIMIT);

endmodule

// File: rtl/video_ctrl_axil_master.sv
// Single-outstanding AXI4-Lite master: turns a command/response handshake into
// one AXI4-Lite read or write at a time.
module video_ctrl_axil_master
  import video_axil_pkg::*;
#(
  parameter int unsigned CTRL_DATA_WIDTH = 32,
  parameter int unsigned CTRL_ADDR_WIDTH = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic                         M_AXI_ACLK,
  input  logic                         M_AXI_ARESETN,
  // Command / response side
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [CTRL_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [CTRL_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [CTRL_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [CTRL_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic                         timeout,
  // AXI4-Lite write address
  output logic [CTRL_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                   M_AXI_AWPROT,
  output logic                         M_AXI_AWVALID,
  input  logic                         M_AXI_AWREADY,
  // AXI4-Lite write data
  output logic [CTRL_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [CTRL_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                         M_AXI_WVALID,
  input  logic                         M_AXI_WREADY,
  // AXI4-Lite write response
  input  logic [1:0]                   M_AXI_BRESP,
  input  logic                         M_AXI_BVALID,
  output logic                         M_AXI_BREADY,
  // AXI4-Lite read address
  output logic [CTRL_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                   M_AXI_ARPROT,
  output logic                         M_AXI_ARVALID,
  input  logic                         M_AXI_ARREADY,
  // AXI4-Lite read data
  input  logic [CTRL_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                   M_AXI_RRESP,
  input  logic                         M_AXI_RVALID,
  output logic                         M_AXI_RREADY
);

  localparam int unsigned SW = CTRL_DATA_WIDTH / 8;

  state_e                     state_q, state_d;
  logic [CTRL_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CTRL_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]              wstrb_q, wstrb_d;
  logic                       aw_done_q, aw_done_d;
  logic                       w_done_q, w_done_d;
  logic [CTRL_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                 resp_q, resp_d;
  logic                       wd_clear, wd_enable;

  // Next-state, capture and handshake logic; all outputs decode from registered state,
  // so VALID/READY drop the instant reset forces the FSM back to IDLE.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    rdata_d       = rdata_q;
    resp_d        = resp_q;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    wd_clear      = 1'b0;
    wd_enable     = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d    = {cmd_addr[CTRL_ADDR_WIDTH-1:2], 2'b00};
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wd_clear  = 1'b1;
          state_d   = cmd_write ? WR_REQ : RD_REQ;
        end
      end

      WR_REQ: begin
        wd_enable     = 1'b1;
        M_AXI_AWVALID = !aw_done_q;
        M_AXI_WVALID  = !w_done_q;
        if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done_d = 1'b1;
        if (M_AXI_WVALID && M_AXI_WREADY)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end

      WR_RESP: begin
        wd_enable    = 1'b1;
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          resp_d   = M_AXI_BRESP;
          rdata_d  = '0;
          wd_clear = 1'b1;
          state_d  = RSP;
        end
      end

      RD_REQ: begin
        wd_enable     = 1'b1;
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) state_d = RD_RESP;
      end

      RD_RESP: begin
        wd_enable    = 1'b1;
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) begin
          rdata_d  = M_AXI_RDATA;
          resp_d   = M_AXI_RRESP;
          wd_clear = 1'b1;
          state_d  = RSP;
        end
      end

      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and capture registers; a reset abandons any transaction in flight.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  axil_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (M_AXI_ACLK),
    .rst_n   (M_AXI_ARESETN),
    .clear_i (wd_clear),
    .enable_i(wd_enable),
    .flag_o  (timeout)
  );

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign rsp_rdata    = rdata_q;
  assign rsp_resp     = resp_q;

endmodule

// File: tb/tb_video_ctrl_axil_master.sv
// Directed bench: AXI4-Lite slave BFM with programmable READY delays, a small
// register file, a protocol monitor, and hand-computed expectations.
module tb_video_ctrl_axil_master;
  import video_axil_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  video_ctrl_axil_master #(
    .CTRL_DATA_WIDTH(32), .CTRL_ADDR_WIDTH(4), .TIMEOUT_CYCLES(256)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .timeout(timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- Slave BFM ----------------
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  int          aw_cnt, w_cnt, ar_cnt;
  logic [1:0]  bresp_cfg = RESP_OKAY;
  logic [1:0]  rresp_cfg = RESP_OKAY;
  logic        force_en = 1'b0;
  logic [31:0] force_data = 32'h0;
  logic        aw_got, w_got;
  logic [3:0]  lat_awaddr, last_wa;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;
  logic [31:0] regs [4];
  logic        aw_now, w_now;
  logic [3:0]  wa, ws;
  logic [31:0] wd;

  assign aw_now = aw_got | (awvalid & awready);
  assign w_now  = w_got | (wvalid & wready);
  assign wa     = aw_got ? lat_awaddr : awaddr;
  assign wd     = w_got ? lat_wdata : wdata;
  assign ws     = w_got ? lat_wstrb : wstrb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      lat_awaddr <= '0; lat_wdata <= '0; lat_wstrb <= '0; last_wa <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
      if (awvalid && !awready && !aw_got) begin
        if (aw_cnt >= aw_dly) begin awready <= 1'b1; aw_cnt <= 0; end
        else aw_cnt <= aw_cnt + 1;
      end
      if (wvalid && !wready && !w_got) begin
        if (w_cnt >= w_dly) begin wready <= 1'b1; w_cnt <= 0; end
        else w_cnt <= w_cnt + 1;
      end
      if (awvalid && awready) begin aw_got <= 1'b1; lat_awaddr <= awaddr; end
      if (wvalid && wready) begin w_got <= 1'b1; lat_wdata <= wdata; lat_wstrb <= wstrb; end
      if (aw_now && w_now && !bvalid) begin
        bvalid  <= 1'b1;
        bresp   <= bresp_cfg;
        aw_got  <= 1'b0;
        w_got   <= 1'b0;
        last_wa <= wa;
        for (int b = 0; b < 4; b++)
          if (ws[b]) regs[wa[3:2]][8*b +: 8] <= wd[8*b +: 8];
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && !arready) begin
        if (ar_cnt >= ar_dly) begin arready <= 1'b1; ar_cnt <= 0; end
        else ar_cnt <= ar_cnt + 1;
      end
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= force_en ? force_data : regs[araddr[3:2]];
        rresp  <= rresp_cfg;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- Protocol monitor (sampled on falling edge) ----------------
  int          prot_err = 0;
  int          b_windows = 0;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_br;
  logic [3:0]  p_awaddr, p_araddr;
  logic [31:0] p_wdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0;
      p_arv <= 1'b0; p_arr <= 1'b0; p_br <= 1'b0;
    end else begin
      if (p_awv && p_awr && awvalid) prot_err <= prot_err + 1;
      if (p_awv && !p_awr && (!awvalid || awaddr != p_awaddr)) prot_err <= prot_err + 1;
      if (p_wv && p_wr && wvalid) prot_err <= prot_err + 1;
      if (p_wv && !p_wr && (!wvalid || wdata != p_wdata)) prot_err <= prot_err + 1;
      if (p_arv && p_arr && arvalid) prot_err <= prot_err + 1;
      if (p_arv && !p_arr && (!arvalid || araddr != p_araddr)) prot_err <= prot_err + 1;
      if (awprot != 3'b000 || arprot != 3'b000) prot_err <= prot_err + 1;
      if (bready && !p_br) b_windows <= b_windows + 1;
      p_awv <= awvalid; p_awr <= awready; p_awaddr <= awaddr;
      p_wv <= wvalid; p_wr <= wready; p_wdata <= wdata;
      p_arv <= arvalid; p_arr <= arready; p_araddr <= araddr;
      p_br <= bready;
    end
  end

  // ---------------- Helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one command and collect its response. lat is the cycle rsp_valid is
  // first seen, counting the acceptance edge as cycle 0.
  task automatic do_cmd(input logic wr, input logic [3:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic [1:0] rs,
                        output int lat, output int to_first, output logic to_last,
                        output logic to_rsp);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check("cmd_ready_seen", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1; to_first = 0; to_last = 1'b0;
    while (!rsp_valid && lat < 2000) begin
      if (timeout && to_first == 0) to_first = lat;
      to_last = timeout;
      @(negedge clk);
      lat++;
    end
    check("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    rd = rsp_rdata; rs = rsp_resp; to_rsp = timeout;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    check("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
  endtask

  // ---------------- Directed sequence ----------------
  logic [31:0] rd;
  logic [1:0]  rs;
  int          lat, to_first, bw0;
  logic        to_last, to_rsp;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_axi_handshakes", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    rst_n = 1'b1;

    // Stray rsp_ready while idle does nothing.
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("stray_rsp_ready_valid", {31'd0, rsp_valid}, 32'd0);
    check("stray_rsp_ready_cmdrdy", {31'd0, cmd_ready}, 32'd1);
    rsp_ready = 1'b0;

    // Zero-wait write then read-back.
    bw0 = b_windows;
    do_cmd(1'b1, 4'h0, 32'h0000_0001, 4'hF, rd, rs, lat, to_first, to_last, to_rsp);
    check("wr0_latency", lat, 32'd4);
    check("wr0_resp", {30'd0, rs}, 32'd0);
    check("wr0_rdata", rd, 32'd0);
    check("wr0_slave_reg", regs[0], 32'h0000_0001);
    check("wr0_b_windows", b_windows - bw0, 32'd1);
    do_cmd(1'b0, 4'h0, 32'h0, 4'h0, rd, rs, lat, to_first, to_last, to_rsp);
    check("rd0_latency", lat, 32'd4);
    check("rd0_rdata", rd, 32'h0000_0001);
    check("rd0_resp", {30'd0, rs}, 32'd0);

    // Unaligned address is forced to word alignment; partial strobes.
    do_cmd(1'b1, 4'h6, 32'hAABB_CCDD, 4'b0101, rd, rs, lat, to_first, to_last, to_rsp);
    check("wr_align_awaddr", {28'd0, last_wa}, 32'h4);
    check("wr_strb_reg", regs[1], 32'h00BB_00DD);
    do_cmd(1'b0, 4'h7, 32'h0, 4'h0, rd, rs, lat, to_first, to_last, to_rsp);
    check("rd_strb_rdata", rd, 32'h00BB_00DD);

    // WREADY three cycles ahead of AWREADY.
    aw_dly = 3; w_dly = 0; bw0 = b_windows;
    do_cmd(1'b1, 4'h8, 32'h0000_0011, 4'hF, rd, rs, lat, to_first, to_last, to_rsp);
    check("w_first_latency", lat, 32'd7);
    check("w_first_b_windows", b_windows - bw0, 32'd1);
    // AWREADY three cycles ahead of WREADY.
    aw_dly = 0; w_dly = 3; bw0 = b_windows;
    do_cmd(1'b1, 4'hC, 32'h0000_0022, 4'hF, rd, rs, lat, to_first, to_last, to_rsp);
    check("aw_first_latency", lat, 32'd7);
    check("aw_first_b_windows", b_windows - bw0, 32'd1);
    // Both READYs in the same cycle.
    aw_dly = 2; w_dly = 2; bw0 = b_windows;
    do_cmd(1'b1, 4'h8, 32'h0000_0033, 4'hF, rd, rs, lat, to_first, to_last, to_rsp);
    check("same_cycle_latency", lat, 32'd6);
    check("same_cycle_b_windows", b_windows - bw0, 32'd1);
    check("same_cycle_reg", regs[2], 32'h0000_0033);
    check("aw_first_reg", regs[3], 32'h0000_0022);
    aw_dly = 0; w_dly = 0;

    // ARREADY stalled for 300 cycles: timeout at cycle 257, cleared in RSP.
    ar_dly = 300;
    do_cmd(1'b0, 4'hC, 32'h0, 4'h0, rd, rs, lat, to_first, to_last, to_rsp);
    check("to_first_cycle", to_first, 32'd257);
    check("to_before_rsp", {31'd0, to_last}, 32'd1);
    check("to_at_rsp", {31'd0, to_rsp}, 32'd0);
    check("to_latency", lat, 32'd304);
    check("to_rdata", rd, 32'h0000_0022);
    ar_dly = 0;

    // SLVERR read with forced data.
    rresp_cfg = RESP_SLVERR; force_en = 1'b1; force_data = 32'hDEAD_BEEF;
    do_cmd(1'b0, 4'h4, 32'h0, 4'h0, rd, rs, lat, to_first, to_last, to_rsp);
    check("slverr_resp", {30'd0, rs}, 32'h2);
    check("slverr_rdata", rd, 32'hDEAD_BEEF);
    rresp_cfg = RESP_OKAY; force_en = 1'b0;

    // DECERR write: response passed through, read data forced to zero.
    bresp_cfg = RESP_DECERR;
    do_cmd(1'b1, 4'h0, 32'h0000_00FF, 4'h1, rd, rs, lat, to_first, to_last, to_rsp);
    check("decerr_resp", {30'd0, rs}, 32'h3);
    check("decerr_rdata", rd, 32'h0);
    bresp_cfg = RESP_OKAY;

    // Reset while AWVALID is high.
    aw_dly = 10; w_dly = 10;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h0; cmd_wdata = 32'h5; cmd_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_awvalid", {31'd0, awvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_handshakes", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    aw_dly = 0; w_dly = 0;
    @(negedge clk);
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    do_cmd(1'b1, 4'h0, 32'h0000_0005, 4'hF, rd, rs, lat, to_first, to_last, to_rsp);
    check("post_rst_wr_latency", lat, 32'd4);
    check("post_rst_wr_resp", {30'd0, rs}, 32'd0);
    do_cmd(1'b0, 4'h0, 32'h0, 4'h0, rd, rs, lat, to_first, to_last, to_rsp);
    check("post_rst_rd_rdata", rd, 32'h0000_0005);

    check("protocol_violations", prot_err, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
